alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised successor to the single-cycle 32-bit MIPS ALU. It keeps the ALUctl opcode set and adds registered outputs, a start/busy/done handshake, and an iterative multiply/divide unit with HI/LO registers for MULT/MULTU/DIV/DIVU/MFHI/MFLO. It sits in the EX stage of the MIPS datapath. It is the execution unit that the multi-cycle control FSM stalls on.

## Interface
- WIDTH, 32, operand/result width (≥8, even)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request; accepted only when busy=0
- ALUctl  input  4  opcode, sampled with start
- A, B  input  WIDTH  operands, sampled with start
- result  output  WIDTH  registered result
- Zero  output  1  result==0; for MULT/DIV: HI==0 && LO==0
- carryFlag  output  1  carry out of ADD/SUB, else 0
- overflowFlag  output  1  signed overflow of ADD/SUB, else 0
- divByZero  output  1  DIV/DIVU with B==0
- illegal  output  1  unused or compiled-out opcode
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when outputs are valid

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL (A<<B[log2 WIDTH-1:0]), 0100 SRL, 0101 SRA, 0110 SUB, 0111 SLT (signed, result 0/1), 1100 NOR, 1101 XOR
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1110 MFHI, 1111 MFLO
- SUB is computed as A+~B+1. carryFlag is the carry out of that sum, so 1 means no borrow.
- ADD/SUB overflow: operands have the same effective sign and the result sign differs.
- MULT/MULTU: {HI,LO} = A*B as a 2·WIDTH-bit product. result=LO.
- DIV/DIVU: LO=quotient, HI=remainder. Quotient truncates toward zero and the remainder takes the sign of A. result=LO.
- Signed multiply/divide use magnitudes, with sign correction in the FIX state.
- Divide by zero: LO=all ones, HI=A, divByZero=1.
- Signed overflow (most-negative / -1): LO=most-negative, HI=0, no flag.
- MFHI/MFLO: result=HI/LO, single-cycle.
- HI/LO change only on completion of MULT*/DIV*.
- FSM states:
  - IDLE: start with a single-cycle op → outputs registered, done=1, stay IDLE. start with MULT*/DIV* → RUN, busy=1, counter=0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for WIDTH cycles, then → FIX.
  - FIX: apply sign corrections, write HI/LO/result/flags, done=1, busy=0 → IDLE.
- start while busy=1 is ignored; A/B/ALUctl changes are ignored after sampling.
- illegal opcode: result=0, flags=0, illegal=1, done after 1 cycle, HI/LO untouched.

## Timing
- Reset values: result=0, all flags 0, busy=0, done=0, HI=LO=0, state IDLE, counter 0.
- Single-cycle ops: start at edge N, then outputs valid and done=1 after edge N+1.
- MULT*/DIV*: start at edge N, busy=1 from N+1 through N+WIDTH+1, then done=1 and busy=0 after edge N+WIDTH+2 (34 cycles for WIDTH=32).
- result and flags hold their values between operations; done is low except for the completion pulse.
- start in the same cycle as done=1 is accepted, giving back-to-back operation.
- reset mid-operation: at the next edge the block returns to IDLE, no done pulse, HI/LO=0, and the partial result is discarded.

## Configuration
- MULDIV_EN defined: full operation as above.
- MULDIV_EN undefined:
  - no HI/LO, iterative datapath, RUN or FIX states
  - opcodes 1000–1011, 1110 and 1111 are illegal (1-cycle, illegal=1)
  - busy and divByZero tied 0

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (ALU_AND … ALU_MFLO)
  - FSM state encoding (IDLE, RUN, FIX)
- Sub-module muldiv_core (WIDTH): iteration counter, partial remainder/product, and sign correction. It has its own start/done and is instantiated only under MULDIV_EN.
- The top level holds the combinational ALU, output registers, HI/LO and the handshake.

## Test plan
- ADD A=0xFFFF_FFFE, B=0x1000_0001 → result=0x0FFF_FFFF, carryFlag=1, overflowFlag=0, done 1 cycle after start.
- SUB A=0x7FFF_FFFF, B=0xFFFF_FFFF → result=0x8000_0000, overflowFlag=1. SLT A=0xFFFF_FFFE, B=1 → result=1.
- MULT A=0xFFFF_FFFE, B=3 → HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, done exactly 34 cycles after start. A second start pulse at cycle 5 is ignored. MFHI then returns 0xFFFF_FFFF.
- DIV A=0xFFFF_FFF9 (-7), B=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU A=0x1234, B=0 → LO=0xFFFF_FFFF, HI=0x1234, divByZero=1.
- MULTU in progress, reset pulsed at cycle 10 → next cycle busy=0, HI=LO=0, result=0, no done. A following ADD works normally.
- MULDIV_EN undefined: MULT A=2, B=3 → done after 1 cycle, illegal=1, result=0, busy never asserted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for alu_multicycle.
// The iterative multiply/divide opcodes are only legal when MULDIV_EN is defined.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SLL   = 4'b0011;
   localparam logic [3:0] ALU_SRL   = 4'b0100;
   localparam logic [3:0] ALU_SRA   = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_MULT  = 4'b1000;
   localparam logic [3:0] ALU_MULTU = 4'b1001;
   localparam logic [3:0] ALU_DIV   = 4'b1010;
   localparam logic [3:0] ALU_DIVU  = 4'b1011;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_XOR   = 4'b1101;
   localparam logic [3:0] ALU_MFHI  = 4'b1110;
   localparam logic [3:0] ALU_MFLO  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } muldivState_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider working on operand magnitudes.
// Only present when MULDIV_EN is defined; results are valid while done_o is high (FIX).
`ifdef MULDIV_EN
module muldiv_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             isDiv_i,
   input  logic             isSigned_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             divByZero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);

   muldivState_t       state_q;
   logic [CW-1:0]      count_q;
   logic [2*WIDTH-1:0] work_q;
   logic [2*WIDTH-1:0] workNext;
   logic [WIDTH-1:0]   operand_q;
   logic [WIDTH-1:0]   aRaw_q;
   logic               isDiv_q, negLo_q, negHi_q, bZero_q;
   logic [WIDTH-1:0]   aMag, bMag;
   logic [WIDTH:0]     addSum, shifted, diff;

   assign aMag = (isSigned_i && a_i[WIDTH-1]) ? -a_i : a_i;
   assign bMag = (isSigned_i && b_i[WIDTH-1]) ? -b_i : b_i;

   // Upper half of work_q is the running product / partial remainder,
   // lower half the multiplier bits / dividend bits turning into quotient bits.
   always_comb begin
      addSum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, operand_q} : '0);
      shifted  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      diff     = shifted - {1'b0, operand_q};
      workNext = {addSum, work_q[WIDTH-1:1]};
      if (isDiv_q) begin
         workNext = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                     work_q[WIDTH-2:0], ~diff[WIDTH]};
      end
   end

   always_comb begin
      hi_o = work_q[2*WIDTH-1:WIDTH];
      lo_o = work_q[WIDTH-1:0];
      if (isDiv_q) begin
         if (bZero_q) begin
            lo_o = '1;
            hi_o = aRaw_q;
         end else begin
            if (negLo_q) lo_o = -work_q[WIDTH-1:0];
            if (negHi_q) hi_o = -work_q[2*WIDTH-1:WIDTH];
         end
      end else if (negLo_q) begin
         {hi_o, lo_o} = -work_q;
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == FIX);
   assign divByZero_o = isDiv_q && bZero_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         work_q    <= '0;
         operand_q <= '0;
         aRaw_q    <= '0;
         isDiv_q   <= 1'b0;
         negLo_q   <= 1'b0;
         negHi_q   <= 1'b0;
         bZero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q   <= RUN;
                  count_q   <= '0;
                  work_q    <= {{WIDTH{1'b0}}, (isDiv_i ? aMag : bMag)};
                  operand_q <= isDiv_i ? bMag : aMag;
                  aRaw_q    <= a_i;
                  isDiv_q   <= isDiv_i;
                  negLo_q   <= isSigned_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  negHi_q   <= isSigned_i && a_i[WIDTH-1];
                  bZero_q   <= (b_i == '0);
               end
            end
            RUN: begin
               work_q  <= workNext;
               count_q <= count_q + 1'b1;
               if (count_q == CW'(WIDTH - 1)) state_q <= FIX;
            end
            FIX: begin
               state_q <= IDLE;
               count_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`endif

// File: rtl/alu_multicycle.sv
// MIPS EX-stage ALU with registered outputs and start/busy/done handshake.
// Define MULDIV_EN to add the iterative MULT/MULTU/DIV/DIVU unit and HI/LO (MFHI/MFLO).
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUctl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
   output logic             Zero,
   output logic             carryFlag,
   output logic             overflowFlag,
   output logic             divByZero,
   output logic             illegal,
   output logic             busy,
   output logic             done
);

   localparam int SW = $clog2(WIDTH);

   logic [WIDTH-1:0] result_q;
   logic             zero_q, carry_q, ovf_q, dbz_q, illegal_q, done_q;
   logic [WIDTH-1:0] aluRes, bEff;
   logic [WIDTH:0]   sum;
   logic             aluCarry, aluOvf, aluIllegal, isMulDiv, isSub, accept;
   logic [SW-1:0]    shamt;

`ifdef MULDIV_EN
   logic [WIDTH-1:0] hi_q, lo_q, coreHi, coreLo;
   logic             coreBusy, coreDone, coreDbz;

   muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
      .clk         (clk),
      .reset       (reset),
      .start_i     (accept && isMulDiv),
      .isDiv_i     (ALUctl[1]),
      .isSigned_i  (~ALUctl[0]),
      .a_i         (A),
      .b_i         (B),
      .busy_o      (coreBusy),
      .done_o      (coreDone),
      .divByZero_o (coreDbz),
      .hi_o        (coreHi),
      .lo_o        (coreLo)
   );

   assign busy = coreBusy;
`else
   assign busy = 1'b0;
`endif

   assign accept = start && !busy;
   assign shamt  = B[SW-1:0];

   // SUB shares the adder as A + ~B + 1, so carry=1 means no borrow.
   always_comb begin
      isSub      = (ALUctl == ALU_SUB);
      bEff       = isSub ? ~B : B;
      sum        = {1'b0, A} + {1'b0, bEff} + {{WIDTH{1'b0}}, isSub};
      aluRes     = '0;
      aluCarry   = 1'b0;
      aluOvf     = 1'b0;
      aluIllegal = 1'b0;
      isMulDiv   = 1'b0;
      case (ALUctl)
         ALU_AND: aluRes = A & B;
         ALU_OR:  aluRes = A | B;
         ALU_NOR: aluRes = ~(A | B);
         ALU_XOR: aluRes = A ^ B;
         ALU_ADD, ALU_SUB: begin
            aluRes   = sum[WIDTH-1:0];
            aluCarry = sum[WIDTH];
            aluOvf   = (A[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         ALU_SLL: aluRes = A << shamt;
         ALU_SRL: aluRes = A >> shamt;
         ALU_SRA: aluRes = $signed(A) >>> shamt;
         ALU_SLT: aluRes = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
`ifdef MULDIV_EN
         ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: isMulDiv = 1'b1;
         ALU_MFHI: aluRes = hi_q;
         ALU_MFLO: aluRes = lo_q;
`endif
         default: aluIllegal = 1'b1;
      endcase
   end

   // Outputs hold between operations; done only pulses on completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
         illegal_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef MULDIV_EN
         hi_q      <= '0;
         lo_q      <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (accept && !isMulDiv) begin
            result_q  <= aluRes;
            zero_q    <= (aluRes == '0) && !aluIllegal;
            carry_q   <= aluCarry;
            ovf_q     <= aluOvf;
            dbz_q     <= 1'b0;
            illegal_q <= aluIllegal;
            done_q    <= 1'b1;
         end
`ifdef MULDIV_EN
         if (coreDone) begin
            hi_q      <= coreHi;
            lo_q      <= coreLo;
            result_q  <= coreLo;
            zero_q    <= (coreHi == '0) && (coreLo == '0);
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            dbz_q     <= coreDbz;
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
         end
`endif
      end
   end

   assign result       = result_q;
   assign Zero         = zero_q;
   assign carryFlag    = carry_q;
   assign overflowFlag = ovf_q;
   assign divByZero    = dbz_q;
   assign illegal      = illegal_q;
   assign done         = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench for alu_multicycle; expectations follow MULDIV_EN.
module tb_alu_multicycle;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   ALUctl = 4'd0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [W-1:0] result;
   logic         Zero, carryFlag, overflowFlag, divByZero, illegal, busy, done;

   typedef struct {
      string        tag;
      logic [W-1:0] res;
      logic         z, c, v, dz, il;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   alu_multicycle #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .ALUctl       (ALUctl),
      .A            (A),
      .B            (B),
      .result       (result),
      .Zero         (Zero),
      .carryFlag    (carryFlag),
      .overflowFlag (overflowFlag),
      .divByZero    (divByZero),
      .illegal      (illegal),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Drives one start pulse (sampled at the next rising edge) and records the expectation.
   task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] res, input logic z,
                                input logic c, input logic v, input logic dz, input logic il,
                                input int lat);
      exp_t e;
      e.tag = tag; e.res = res; e.z = z; e.c = c; e.v = v; e.dz = dz; e.il = il; e.lat = lat;
      @(negedge clk);
      ALUctl = op; A = a; B = b; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // n0 = negedges already elapsed since the start pulse was driven.
   task automatic checkOutput(input int n0);
      int   n = n0;
      exp_t e;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkValue("scoreboard depth", W'(sb.size()), W'(1));
      if (sb.size() == 0) return;
      e = sb.pop_front();
      checkValue({e.tag, " done"}, W'(done), W'(1));
      checkValue({e.tag, " latency"}, W'(n), W'(e.lat));
      checkValue({e.tag, " result"}, result, e.res);
      checkValue({e.tag, " Zero"}, W'(Zero), W'(e.z));
      checkValue({e.tag, " carryFlag"}, W'(carryFlag), W'(e.c));
      checkValue({e.tag, " overflowFlag"}, W'(overflowFlag), W'(e.v));
      checkValue({e.tag, " divByZero"}, W'(divByZero), W'(e.dz));
      checkValue({e.tag, " illegal"}, W'(illegal), W'(e.il));
      @(negedge clk);
      checkValue({e.tag, " done pulse"}, W'(done), W'(0));
   endtask

   initial begin
      logic sawDone;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkValue("reset result", result, '0);
      checkValue("reset Zero", W'(Zero), W'(0));
      checkValue("reset carry", W'(carryFlag), W'(0));
      checkValue("reset ovf", W'(overflowFlag), W'(0));
      checkValue("reset dbz", W'(divByZero), W'(0));
      checkValue("reset illegal", W'(illegal), W'(0));
      checkValue("reset busy", W'(busy), W'(0));
      checkValue("reset done", W'(done), W'(0));

      applyStimulus("ADD", ALU_ADD, 32'hFFFF_FFFE, 32'h1000_0001, 32'h0FFF_FFFF, 0, 1, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("SUB ovf", ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1, 0, 0, 1);
      checkOutput(1);
      applyStimulus("SUB zero", ALU_SUB, 32'd5, 32'd5, 32'd0, 1, 1, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("SLT", ALU_SLT, 32'hFFFF_FFFE, 32'd1, 32'd1, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("AND", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("OR", ALU_OR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("NOR", ALU_NOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("XOR", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("SLL", ALU_SLL, 32'h8000_0001, 32'h0000_0024, 32'h0000_0010, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("SRL", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("SRA", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 0, 0, 0, 1);
      checkOutput(1);

`ifdef MULDIV_EN
      applyStimulus("MULT", ALU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 0, 0, 0, 0, 0, 34);
      repeat (3) @(negedge clk);
      checkValue("MULT busy", W'(busy), W'(1));
      ALUctl = ALU_ADD; A = 32'd1; B = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput(5);
      applyStimulus("MFHI mult", ALU_MFHI, '0, '0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("MFLO mult", ALU_MFLO, '0, '0, 32'hFFFF_FFFA, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("MULTU", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 0, 34);
      checkOutput(1);
      applyStimulus("MFHI multu", ALU_MFHI, '0, '0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("MULTU zero", ALU_MULTU, 32'h1234, 32'd0, 32'd0, 1, 0, 0, 0, 0, 34);
      checkOutput(1);
      applyStimulus("DIV", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, 0, 0, 0, 34);
      checkOutput(1);
      applyStimulus("MFHI div", ALU_MFHI, '0, '0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("DIVU by zero", ALU_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 34);
      checkOutput(1);
      applyStimulus("MFHI divu0", ALU_MFHI, '0, '0, 32'h0000_1234, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("DIV ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 0, 0, 34);
      checkOutput(1);
      applyStimulus("MFHI divovf", ALU_MFHI, '0, '0, 32'd0, 1, 0, 0, 0, 0, 1);
      checkOutput(1);

      applyStimulus("MULTU reset", ALU_MULTU, 32'hFFFF_FFFF, 32'd7, '0, 0, 0, 0, 0, 0, 34);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      checkValue("abort busy", W'(busy), W'(0));
      checkValue("abort done", W'(done), W'(0));
      checkValue("abort result", result, '0);
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) sawDone = 1'b1;
      end
      checkValue("abort no done", W'(sawDone), W'(0));
      applyStimulus("MFHI after reset", ALU_MFHI, '0, '0, 32'd0, 1, 0, 0, 0, 0, 1);
      checkOutput(1);
      applyStimulus("MFLO after reset", ALU_MFLO, '0, '0, 32'd0, 1, 0, 0, 0, 0, 1);
      checkOutput(1);
`else
      applyStimulus("MULT illegal", ALU_MULT, 32'd2, 32'd3, 32'd0, 0, 0, 0, 0, 1, 1);
      checkValue("MULT busy", W'(busy), W'(0));
      checkOutput(1);
      applyStimulus("DIVU illegal", ALU_DIVU, 32'h1234, 32'd0, 32'd0, 0, 0, 0, 0, 1, 1);
      checkValue("DIVU busy", W'(busy), W'(0));
      checkOutput(1);
      applyStimulus("MFHI illegal", ALU_MFHI, '0, '0, 32'd0, 0, 0, 0, 0, 1, 1);
      checkOutput(1);
`endif

      applyStimulus("ADD final", ALU_ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0, 0, 1);
      checkOutput(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
